display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
//
// PURPOSE
//   Time-multiplexes NUM_DIGITS BCD digits of the calculator result onto one shared
//   7-segment decoder and a common-segment, per-digit-anode display.
//   Double-buffers the displayed value: a new value is loaded through a valid/ready
//   handshake and shown only from the next frame boundary, so a frame never tears.
//   Sits between the calculator datapath (producer) and the BCD-to-7-segment decoder.
//
// PARAMETERS
//   NUM_DIGITS    4     number of display digits (2..8); digit 0 = rightmost
//   PRESCALE      50000 clock cycles each digit is lit per scan (>=1)
//   GUARD_CYCLES  2     all-anodes-off cycles before each digit (>=1), anti-ghosting
//
// PORTS
//   clock        in   1             system clock, rising edge
//   reset_n      in   1             asynchronous, active-low reset
//   value_in     in   4*NUM_DIGITS  BCD digits; [3:0] = digit 0
//   dp_in        in   NUM_DIGITS    decimal-point request per digit
//   value_valid  in   1             producer offers value_in/dp_in
//   value_ready  out  1             block can accept; transfer when valid && ready
//   data         out  4             BCD code of the digit currently selected (to decoder)
//   dp           out  1             decimal point for the selected digit
//   an_n         out  NUM_DIGITS    anode enables, active-low, at most one low
//   frame_start  out  1             1-cycle pulse when the scan restarts at digit 0
//
// BEHAVIOUR
//   - Registers: pending{val,dp} + pending_full; active{val,dp}; state; idx; cnt.
//   - Reset: state=GUARD, idx=0, cnt=0, active=0, pending=0, pending_full=0,
//     an_n=all 1, data=0, dp=0, value_ready=1, frame_start=0.
//   - value_ready = !pending_full (registered-state combinational).
//   - Accept (valid && ready): pending <= inputs, pending_full <= 1 next edge.
//   - FSM, all outputs registered:
//     GUARD: an_n all 1; data/dp = active digit idx. After GUARD_CYCLES cycles -> SHOW, cnt=0.
//     SHOW : an_n[idx]=0, others 1. After PRESCALE cycles -> GUARD, cnt=0, idx advances.
//   - idx advance: idx==NUM_DIGITS-1 wraps to 0 (frame boundary), else idx+1.
//   - Frame boundary: if pending_full (value before this edge), active <= pending and
//     pending_full <= 0; frame_start=1 for the first GUARD cycle of the new frame.
//     An accept cannot coincide with a transfer (ready=0 while full); a value accepted
//     on the boundary edge itself stays pending until the following boundary.
//   - Invalid BCD (code > 9) in a digit: that digit's anode stays high in SHOW (blank);
//     timing unchanged; data still presents the raw code.
//   - Holding valid with ready low: no effect; producer must hold data stable.
//   - Reset mid-scan: immediate return to reset values; pending value discarded.
//   - Frame period = NUM_DIGITS*(GUARD_CYCLES+PRESCALE) cycles.
//
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: in SHOW, digit idx is blanked (an_n stays all 1)
//     when it and every more-significant digit are 0, except digit 0 is never blanked
//     ("0007" shows as "   7"; "0000" shows "   0"). dp request on a digit overrides
//     blanking for that digit and all lower digits.
//   Undefined: all digits with codes 0..9 are lit, zeros included.
//
// TESTING (NUM_DIGITS=4, PRESCALE=4, GUARD_CYCLES=1)
//   - Reset release, no load -> an_n sequence 1111,1110x4,1111,1101x4,...; frame_start
//     once per 20 cycles; data=0.
//   - Load 0x1234 mid-frame -> ready drops next cycle; old value until boundary; then data
//     shows 4,3,2,1 with an_n 1110,1101,1011,0111; ready returns 1.
//   - Two back-to-back valids (0x1111, 0x2222) -> second stalls (ready=0) until boundary,
//     frame N+1 shows 1111, frame N+2 shows 2222; no value lost or torn.
//   - Digit 2 = 0xC -> an_n never 1011 in SHOW; other digits normal; period still 20.
//   - Assert reset_n=0 during SHOW of digit 2 with pending_full=1 -> an_n=1111, ready=1
//     immediately; after release, scan restarts at digit 0 with active=0.
//   - LEADING_ZERO_BLANK_EN, load 0x0070, dp_in=0 -> only digits 0,1 lit; with
//     dp_in=4'b0100 -> digits 0..2 lit.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned double buffer
//
// Purpose:
//   Scans NUM_DIGITS BCD digits onto one shared 7-segment decoder and a
//   per-digit active-low anode bus. Each digit slot is GUARD_CYCLES cycles
//   with every anode off, then PRESCALE cycles with that digit's anode low.
//   A new value is taken through a valid/ready handshake into a pending
//   buffer and promoted to the displayed (active) buffer only at the frame
//   boundary, so a frame always shows one consistent value.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, leading zero digits are blanked during SHOW; digit 0 is
//   never blanked, and a decimal-point request on a digit keeps that digit
//   and every lower digit lit.
//
// Ports:
//   clock        in   rising-edge system clock
//   reset_n      in   asynchronous active-low reset
//   value_in     in   [4*NUM_DIGITS-1:0] BCD digits, [3:0] = digit 0 (rightmost)
//   dp_in        in   [NUM_DIGITS-1:0] decimal-point request per digit
//   value_valid  in   producer offers value_in/dp_in
//   value_ready  out  pending buffer empty; transfer on valid && ready
//   data         out  [3:0] BCD code of the selected digit (to the decoder)
//   dp           out  decimal point of the selected digit
//   an_n         out  [NUM_DIGITS-1:0] active-low anodes, at most one low
//   frame_start  out  one-cycle pulse on the first guard cycle of a new frame

module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [3:0]              data,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (PRESCALE > GUARD_CYCLES) ? PRESCALE : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_full;
  logic [4*NUM_DIGITS-1:0] act_val, act_val_nxt;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt;

  logic                    accept;
  logic                    swap;

  logic [3:0]              data_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   an_n_nxt;
  logic                    lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    seen;
`endif

  assign value_ready = ~pend_full;
  assign accept      = value_valid & ~pend_full;
  // Promotion uses pend_full as it was before the boundary edge; an accept
  // cannot happen in the same cycle because ready is low while full.
  assign swap        = wrap & pend_full;

  // Scan sequencing: guard slot, then show slot, then next digit.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    wrap      = 1'b0;
    case (state)
      ST_GUARD: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt == SHOW_LAST) begin
          state_nxt = ST_GUARD;
          cnt_nxt   = '0;
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
            wrap    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_GUARD;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so that an_n/data/dp
  // always describe the state the FSM is in during the same cycle.
  always_comb begin
    act_val_nxt = swap ? pend_val : act_val;
    act_dp_nxt  = swap ? pend_dp  : act_dp;
    data_nxt    = 4'd0;
    dp_nxt      = 1'b0;
    an_n_nxt    = '1;
    lit         = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    seen        = 1'b0;
`endif
    // Walk from the most significant digit down so that "something nonzero
    // or a dp request at or above this digit" is known when idx is reached.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
      seen = seen | (act_val_nxt[4*i +: 4] != 4'd0) | act_dp_nxt[i];
`endif
      if (IDX_W'(i) == idx_nxt) begin
        data_nxt = act_val_nxt[4*i +: 4];
        dp_nxt   = act_dp_nxt[i];
`ifdef LEADING_ZERO_BLANK_EN
        lit      = seen | (i == 0);
`else
        lit      = 1'b1;
`endif
        // Codes above 9 keep the slot timing but leave the digit dark.
        if ((state_nxt == ST_SHOW) && lit && (data_nxt <= 4'd9)) begin
          an_n_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_GUARD;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else begin
      act_val <= act_val_nxt;
      act_dp  <= act_dp_nxt;
      if (accept) begin
        pend_val  <= value_in;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end else if (swap) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an_n        <= '1;
      data        <= 4'd0;
      dp          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      an_n        <= an_n_nxt;
      data        <= data_nxt;
      dp          <= dp_nxt;
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - randomized self-checking bench for display_scan_ctrl
module tb_display_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int GC    = 1;
  localparam int SLOT  = GC + PS;
  localparam int FRAME = ND * SLOT;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        value_valid = 1'b0;
  logic        value_ready;
  logic [3:0]  data;
  logic        dp;
  logic [3:0]  an_n;
  logic        frame_start;

  always #5 clock = ~clock;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .PRESCALE    (PS),
    .GUARD_CYCLES(GC)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .data       (data),
    .dp         (dp),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: k = rising edges since reset release; the displayed
  // slot follows from k by plain arithmetic.
  int unsigned k;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pend_full;

  logic [15:0] q_val[$];
  logic [3:0]  q_dp[$];
  logic        offer = 1'b0;
  logic [15:0] offer_val = '0;
  logic [3:0]  offer_dp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic logic [3:0] exp_an(input int unsigned kk);
    int p;
    int dig;
    logic [3:0] code;
    logic lit;
    p = int'(kk % FRAME);
    dig = p / SLOT;
    exp_an = 4'hF;
    if ((p % SLOT) >= GC) begin
      code = 4'((m_act >> (4 * dig)) & 16'hF);
      lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      if (dig != 0 && (m_act >> (4 * dig)) == 16'd0 && (m_act_dp >> dig) == 4'd0) lit = 1'b0;
`endif
      if (lit && code <= 4'd9) exp_an[dig] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    int p;
    int dig;
    p = int'(k % FRAME);
    dig = p / SLOT;
    check("an_n", 32'(an_n), 32'(exp_an(k)));
    check("data", 32'(data), 32'((m_act >> (4 * dig)) & 16'hF));
    check("dp", 32'(dp), 32'(m_act_dp[dig]));
    check("frame_start", 32'(frame_start), 32'(k != 0 && p == 0));
    check("value_ready", 32'(value_ready), 32'(!m_pend_full));
  endtask

  // Called positioned at a falling edge; returns at the next falling edge.
  task automatic tick();
    logic acc;
    check_outputs();
    if (!offer && q_val.size() > 0) begin
      offer     = 1'b1;
      offer_val = q_val.pop_front();
      offer_dp  = q_dp.pop_front();
    end
    value_valid = offer;
    value_in    = offer ? offer_val : 16'($urandom);
    dp_in       = offer ? offer_dp  : 4'($urandom);
    acc = offer && !m_pend_full;
    @(posedge clock);
    k++;
    if ((k % FRAME) == 0 && m_pend_full) begin
      m_act       = m_pend;
      m_act_dp    = m_pend_dp;
      m_pend_full = 1'b0;
    end
    if (acc) begin
      m_pend      = offer_val;
      m_pend_dp   = offer_dp;
      m_pend_full = 1'b1;
      offer       = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] d);
    q_val.push_back(v);
    q_dp.push_back(d);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    int r;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      r = $urandom_range(0, 13);
      v[4*i +: 4] = (r > 11) ? 4'd0 : 4'(r);
    end
    return v;
  endfunction

  task automatic model_reset();
    k = 0;
    m_act = '0;
    m_act_dp = '0;
    m_pend = '0;
    m_pend_dp = '0;
    m_pend_full = 1'b0;
  endtask

  initial begin
    int bound;
    model_reset();
    @(negedge clock);
    check_outputs();
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;

    // Idle scan, no value loaded.
    repeat (45) tick();

    // Single load mid-frame.
    repeat (7) tick();
    push(16'h1234, 4'b0000);
    repeat (45) tick();

    // Back-to-back offers: second stalls until the boundary.
    push(16'h1111, 4'b0000);
    push(16'h2222, 4'b0000);
    repeat (70) tick();

    // Invalid BCD in digit 2.
    push(16'h0C56, 4'b0010);
    repeat (45) tick();

    // Leading zeros, with and without a dp request.
    push(16'h0070, 4'b0000);
    repeat (45) tick();
    push(16'h0070, 4'b0100);
    repeat (45) tick();
    push(16'h0000, 4'b0000);
    repeat (45) tick();

    // Randomized producer traffic.
    repeat (1500) begin
      if ($urandom_range(0, 29) == 0)
        push(rand_val(), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      tick();
    end
    repeat (100) tick();

    // Reset during SHOW of digit 2 with a value pending.
    push(rand_val(), 4'h0);
    bound = 0;
    while (!(m_pend_full && ((k % FRAME) / SLOT) == 2 && ((k % FRAME) % SLOT) >= GC)
           && bound < 200) begin
      tick();
      bound++;
    end
    check("reset_setup_reached", 32'(bound < 200), 32'd1);
    reset_n = 1'b0;
    value_valid = 1'b0;
    q_val.delete();
    q_dp.delete();
    offer = 1'b0;
    model_reset();
    #1;
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_ready", 32'(value_ready), 32'd1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    @(negedge clock);
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
    repeat (45) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
